pc_sequencer: RTL and testbench

Parametrised program-counter sequencer that generates the instruction-fetch address each cycle. It supports sequential increment, absolute jump, PC-relative branch, stall, and call/return through an internal return-address stack. It sits at the head of the fetch stage, between the control unit that issues redirect commands and the instruction memory address port. It replaces the fixed 16-bit increment/load counter.

---
 rtl/pc_sequencer_pkg.sv | 17 +
 rtl/pc_return_stack.sv | 60 ++++++
 rtl/pc_sequencer.sv | 130 +++++++++++++
 tb/tb_pc_sequencer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the fetch-address sequencer: next-PC select codes and
// the default address width / increment used by fetch and the control unit.
package pc_sequencer_pkg;

   localparam int          PC_WIDTH_DEFAULT = 16;
   localparam int unsigned PC_STEP_DEFAULT  = 1;

   typedef enum logic [2:0] {
      PCSEL_INC  = 3'd0,
      PCSEL_JMP  = 3'd1,
      PCSEL_BR   = 3'd2,
      PCSEL_CALL = 3'd3,
      PCSEL_RET  = 3'd4,
      PCSEL_HOLD = 3'd5
   } pcsel_t;

endpackage

// File: rtl/pc_return_stack.sv
// Circular return-address stack with occupancy count; a push when full
// overwrites the oldest entry, a pop when empty leaves the stack untouched.
module pc_return_stack #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] push_data,
   output logic [WIDTH-1:0] top,
   output logic             full,
   output logic             empty,
   output logic             overflow,
   output logic             underflow
);

   localparam int            PW      = $clog2(DEPTH);
   localparam logic [PW-1:0] PTR_ONE = PW'(1);
   localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
   localparam logic [PW:0]   CNT_MAX = (PW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    top_ptr;
   logic [PW-1:0]    ptr_up;
   logic [PW-1:0]    ptr_dn;
   logic [PW:0]      count;

   assign ptr_up    = top_ptr + PTR_ONE;
   assign ptr_dn    = top_ptr - PTR_ONE;
   assign full      = (count == CNT_MAX);
   assign empty     = (count == '0);
   assign top       = mem[top_ptr];
   assign overflow  = push & full;
   assign underflow = pop & empty;

   // Entry storage carries no reset; only the pointer and count define validity.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[ptr_up] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         top_ptr <= '1;
         count   <= '0;
      end else if (push) begin
         top_ptr <= ptr_up;
         if (!full) begin
            count <= count + CNT_ONE;
         end
      end else if (pop && !empty) begin
         top_ptr <= ptr_dn;
         count   <= count - CNT_ONE;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-address sequencer: priority next-PC mux, PC register and sticky stack
// error. The return stack is built only when PC_SEQ_RAS_EN is defined.
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter int               WIDTH        = PC_WIDTH_DEFAULT,
   parameter int unsigned      STEP         = PC_STEP_DEFAULT,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
   parameter int               STACK_DEPTH  = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             pc_write_enable,
   input  logic [WIDTH-1:0] pc_in,
   input  logic             branch_enable,
   input  logic [WIDTH-1:0] branch_offset,
   input  logic             call_enable,
   input  logic             ret_enable,
   output logic [WIDTH-1:0] pc_out,
   output logic             ras_full,
   output logic             ras_empty,
   output logic             ras_error
);

   localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

   if (STACK_DEPTH < 2 || (STACK_DEPTH & (STACK_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("STACK_DEPTH must be a power of two and at least 2");
   end

   pcsel_t           sel;
   logic [WIDTH-1:0] pc_p0;
   logic [WIDTH-1:0] pc_next;
   logic [WIDTH-1:0] pc_inc;
   logic [WIDTH-1:0] pc_br;
   logic [WIDTH-1:0] ras_top;
   logic             stk_empty;

   assign pc_inc = pc_p0 + STEP_W;
   // Two's-complement offset: modulo-2^WIDTH addition is identical for signed values.
   assign pc_br  = pc_p0 + branch_offset;
   assign pc_out = pc_p0;

   always_comb begin
      sel = PCSEL_INC;
      if (stall) begin
         sel = PCSEL_HOLD;
`ifdef PC_SEQ_RAS_EN
      end else if (ret_enable) begin
         sel = PCSEL_RET;
      end else if (call_enable) begin
         sel = PCSEL_CALL;
`else
      end else if (call_enable) begin
         sel = PCSEL_JMP;
`endif
      end else if (pc_write_enable) begin
         sel = PCSEL_JMP;
      end else if (branch_enable) begin
         sel = PCSEL_BR;
      end
   end

   always_comb begin
      pc_next = pc_inc;
      case (sel)
         PCSEL_HOLD: pc_next = pc_p0;
         PCSEL_RET:  pc_next = stk_empty ? pc_inc : ras_top;
         PCSEL_CALL: pc_next = pc_in;
         PCSEL_JMP:  pc_next = pc_in;
         PCSEL_BR:   pc_next = pc_br;
         default:    pc_next = pc_inc;
      endcase
   end

   // Stage p0: PC register
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_p0 <= RESET_VECTOR;
      end else begin
         pc_p0 <= pc_next;
      end
   end

`ifdef PC_SEQ_RAS_EN
   logic stk_full;
   logic stk_ovf;
   logic stk_unf;
   logic error_p0;

   pc_return_stack #(
      .WIDTH (WIDTH),
      .DEPTH (STACK_DEPTH)
   ) u_ras (
      .clk       (clk),
      .reset     (reset),
      .push      (sel == PCSEL_CALL),
      .pop       (sel == PCSEL_RET),
      .push_data (pc_inc),
      .top       (ras_top),
      .full      (stk_full),
      .empty     (stk_empty),
      .overflow  (stk_ovf),
      .underflow (stk_unf)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         error_p0 <= 1'b0;
      end else begin
         error_p0 <= error_p0 | stk_ovf | stk_unf;
      end
   end

   assign ras_full  = stk_full;
   assign ras_empty = stk_empty;
   assign ras_error = error_p0;
`else
   logic unused_ret;

   assign unused_ret = ret_enable;
   assign ras_top    = '0;
   assign stk_empty  = 1'b1;
   assign ras_full   = 1'b0;
   assign ras_empty  = 1'b1;
   assign ras_error  = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a queue-based reference model predicts each
// cycle's outputs; a monitor compares them after every rising edge.
module tb_pc_sequencer;

   localparam int          W     = 16;
   localparam int          DEPTH = 4;
   localparam logic [W-1:0] RV   = '0;

   typedef struct packed {
      logic [W-1:0] pc;
      logic         full;
      logic         empty;
      logic         err;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         stall = 1'b0;
   logic         pc_write_enable = 1'b0;
   logic [W-1:0] pc_in = '0;
   logic         branch_enable = 1'b0;
   logic [W-1:0] branch_offset = '0;
   logic         call_enable = 1'b0;
   logic         ret_enable = 1'b0;
   logic [W-1:0] pc_out;
   logic         ras_full;
   logic         ras_empty;
   logic         ras_error;

   int checks = 0;
   int passes = 0;

   exp_t         exp_q[$];
   logic [W-1:0] m_ras[$];
   logic [W-1:0] m_pc  = RV;
   logic         m_err = 1'b0;

   pc_sequencer #(
      .WIDTH        (W),
      .STEP         (1),
      .RESET_VECTOR (RV),
      .STACK_DEPTH  (DEPTH)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .stall           (stall),
      .pc_write_enable (pc_write_enable),
      .pc_in           (pc_in),
      .branch_enable   (branch_enable),
      .branch_offset   (branch_offset),
      .call_enable     (call_enable),
      .ret_enable      (ret_enable),
      .pc_out          (pc_out),
      .ras_full        (ras_full),
      .ras_empty       (ras_empty),
      .ras_error       (ras_error)
   );

   always #5 clk = ~clk;

   // Reference model: the stack is a queue, newest at the back.
   task automatic model(input logic r, st, we, input logic [W-1:0] pin,
                        input logic be, input logic [W-1:0] off, input logic ce, re);
      if (r) begin
         m_pc  = RV;
         m_err = 1'b0;
         m_ras.delete();
      end else if (st) begin
         m_pc = m_pc;
`ifdef PC_SEQ_RAS_EN
      end else if (re) begin
         if (m_ras.size() == 0) begin
            m_pc  = m_pc + 16'd1;
            m_err = 1'b1;
         end else begin
            m_pc = m_ras.pop_back();
         end
      end else if (ce) begin
         if (m_ras.size() == DEPTH) begin
            void'(m_ras.pop_front());
            m_err = 1'b1;
         end
         m_ras.push_back(m_pc + 16'd1);
         m_pc = pin;
`else
      end else if (ce) begin
         m_pc = pin;
`endif
      end else if (we) begin
         m_pc = pin;
      end else if (be) begin
         m_pc = m_pc + off;
      end else begin
         m_pc = m_pc + 16'd1;
      end
   endtask

   task automatic step(input logic r, st, we, input logic [W-1:0] pin,
                       input logic be, input logic [W-1:0] off, input logic ce, re);
      exp_t e;
      @(negedge clk);
      reset           = r;
      stall           = st;
      pc_write_enable = we;
      pc_in           = pin;
      branch_enable   = be;
      branch_offset   = off;
      call_enable     = ce;
      ret_enable      = re;
      model(r, st, we, pin, be, off, ce, re);
      e.pc = m_pc;
`ifdef PC_SEQ_RAS_EN
      e.full  = (m_ras.size() == DEPTH);
      e.empty = (m_ras.size() == 0);
      e.err   = m_err;
`else
      e.full  = 1'b0;
      e.empty = 1'b1;
      e.err   = 1'b0;
`endif
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, '0, 0, '0, 0, 0);
   endtask

   task automatic do_reset();
      step(1, 0, 0, '0, 0, '0, 0, 0);
   endtask

   task automatic jump(input logic [W-1:0] a);
      step(0, 0, 1, a, 0, '0, 0, 0);
   endtask

   task automatic call(input logic [W-1:0] a);
      step(0, 0, 0, a, 0, '0, 1, 0);
   endtask

   task automatic ret();
      step(0, 0, 0, '0, 0, '0, 0, 1);
   endtask

   // Monitor: the DUT presents a new PC every cycle.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (pc_out === e.pc) passes++;
            else $display("FAIL pc_out: got %h expected %h at %0t", pc_out, e.pc, $time);
            checks++;
            if ({ras_full, ras_empty, ras_error} === {e.full, e.empty, e.err}) passes++;
            else $display("FAIL ras_flags(full,empty,err): got %b%b%b expected %b%b%b at %0t",
                          ras_full, ras_empty, ras_error, e.full, e.empty, e.err, $time);
         end
      end
   end

   initial begin
      // reset then idle count-up
      do_reset();
      idle(4);
      // nested calls from pc 5
      idle(1);
      call(16'h0100);
      idle(1);
      call(16'h0200);
      ret();
      ret();
      // jump then increment
      jump(16'h1234);
      idle(2);
      // negative branch and silent wrap
      jump(16'h0010);
      step(0, 0, 0, '0, 1, 16'hFFF8, 0, 0);
      jump(16'hFFFF);
      idle(2);
      // overflow then underflow
      do_reset();
      for (int i = 0; i < 5; i++) call(16'h0400 + 16'(i * 16'h0010));
      for (int i = 0; i < 5; i++) ret();
      idle(2);
      // stall with call, then ret+call together, back-to-back call/ret
      do_reset();
      call(16'h0300);
      step(0, 1, 0, 16'h0777, 0, '0, 1, 0);
      step(0, 1, 0, 16'h0777, 0, '0, 1, 0);
      step(0, 0, 0, 16'h0888, 0, '0, 1, 1);
      call(16'h0500);
      ret();
      call(16'h0600);
      // reset during a call
      step(1, 0, 0, 16'h0999, 0, '0, 1, 0);
      idle(1);
      // randomized mix
      for (int i = 0; i < 600; i++) begin
         int r;
         r = $urandom_range(99, 0);
         step(r < 2, r >= 2 && r < 15, $urandom_range(3, 0) == 0, W'($urandom),
              $urandom_range(2, 0) == 0, W'($urandom),
              r >= 15 && r < 40, (r >= 30 && r < 55));
      end
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() == 0) passes++;
      else $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
